// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame buffer geometry, widths and fill FSM types
package fb_pkg;

  localparam int FB_WIDTH_DEF  = 160;
  localparam int FB_HEIGHT_DEF = 120;
  localparam int FB_ADDR_W     = 15;
  localparam int FB_DATA_W     = 12;
  localparam int X_W           = 8;
  localparam int Y_W           = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  typedef struct packed {
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    logic           empty;
  } clip_t;

endpackage

// File: rtl/fb_fill_engine_if.sv
// rtl/fb_fill_engine_if.sv - fill request and frame buffer write port bundle
interface fb_fill_engine_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);
  logic              start;
  logic              abort;
  logic              stall;
  logic [X_W-1:0]    x0;
  logic [Y_W-1:0]    y0;
  logic [X_W-1:0]    width;
  logic [Y_W-1:0]    height;
  logic [DATA_W-1:0] color;
  logic              busy;
  logic              done;
  logic              fb_wen;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_din;

  modport master (
    output start, abort, stall, x0, y0, width, height, color,
    input  busy, done, fb_wen, fb_addr, fb_din
  );

  modport slave (
    input  start, abort, stall, x0, y0, width, height, color,
    output busy, done, fb_wen, fb_addr, fb_din
  );
endinterface

// File: rtl/fb_rect_clip.sv
// rtl/fb_rect_clip.sv - clips a fill rectangle against the frame buffer edges
module fb_rect_clip
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  output clip_t          clip
);

  // One extra bit so a full-width room (e.g. 256) still compares correctly.
  localparam logic [X_W:0] FBW = (X_W+1)'(FB_WIDTH);
  localparam logic [Y_W:0] FBH = (Y_W+1)'(FB_HEIGHT);

  logic [X_W:0] x_room;
  logic [Y_W:0] y_room;

  // Remaining room to the right/bottom edge, then min() against the request.
  always_comb begin
    x_room     = FBW - {1'b0, x0};
    y_room     = FBH - {1'b0, y0};
    clip.empty = ({1'b0, x0} >= FBW) || ({1'b0, y0} >= FBH) ||
                 (width == '0) || (height == '0);
    clip.w     = ({1'b0, width} < x_room) ? width : x_room[X_W-1:0];
    clip.h     = ({1'b0, height} < y_room) ? height : y_room[Y_W-1:0];
  end

endmodule

// File: rtl/fb_fill_engine.sv
// rtl/fb_fill_engine.sv - rectangle fill engine writing one pixel per cycle
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W
) (
  input  logic          clock,
  input  logic          nreset,
  fb_fill_engine_if.slave bus
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

  fill_state_t       state, state_nxt;
  logic [X_W-1:0]    x0_q, width_q, w_q, col;
  logic [Y_W-1:0]    y0_q, height_q, h_q, row;
  logic [DATA_W-1:0] color_q, fb_din_q;
  logic [ADDR_W-1:0] fb_addr_q, row_base, start_addr;
  clip_t             clip;
  logic              accept, adv, last_col, last_row;

  fb_rect_clip #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT)
  ) u_clip (
    .x0     (x0_q),
    .y0     (y0_q),
    .width  (width_q),
    .height (height_q),
    .clip   (clip)
  );

  // The only multiply: the first pixel address, used once while in SETUP.
  assign start_addr = ADDR_W'(y0_q) * ROW_STEP + ADDR_W'(x0_q);

  assign accept   = (state == ST_IDLE) && bus.start && !bus.abort;
  assign adv      = (state == ST_FILL) && !bus.stall && !bus.abort;
  assign last_col = (col == w_q - 1'b1);
  assign last_row = (row == h_q - 1'b1);

  assign bus.fb_wen  = adv;
  assign bus.busy    = (state == ST_SETUP) || (state == ST_FILL);
  assign bus.done    = (state == ST_DONE);
  assign bus.fb_addr = fb_addr_q;
  assign bus.fb_din  = fb_din_q;

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: abort wins everywhere; empty rectangles skip straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SETUP;
      ST_SETUP: begin
        if (bus.abort)       state_nxt = ST_IDLE;
        else if (clip.empty) state_nxt = ST_DONE;
        else                 state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (bus.abort)                        state_nxt = ST_IDLE;
        else if (adv && last_col && last_row) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, clipped extents, raster counters and write address.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      x0_q      <= '0;
      y0_q      <= '0;
      width_q   <= '0;
      height_q  <= '0;
      color_q   <= '0;
      w_q       <= '0;
      h_q       <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      fb_addr_q <= '0;
      fb_din_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x0_q     <= bus.x0;
            y0_q     <= bus.y0;
            width_q  <= bus.width;
            height_q <= bus.height;
            color_q  <= bus.color;
          end
        end
        ST_SETUP: begin
          if (!bus.abort && !clip.empty) begin
            w_q       <= clip.w;
            h_q       <= clip.h;
            col       <= '0;
            row       <= '0;
            row_base  <= start_addr;
            fb_addr_q <= start_addr;
            fb_din_q  <= color_q;
          end
        end
        ST_FILL: begin
          // The address is left on the final pixel, so it never runs past it.
          if (adv && !last_col) begin
            col       <= col + 1'b1;
            fb_addr_q <= fb_addr_q + 1'b1;
          end else if (adv && !last_row) begin
            col       <= '0;
            row       <= row + 1'b1;
            row_base  <= row_base + ROW_STEP;
            fb_addr_q <= row_base + ROW_STEP;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
